// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    // Legal operand width range for the controller.
    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 32;

    // Controller states, fixed 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Bit counter width: enough to count 0..WIDTH-1, never narrower than 1 bit.
    function automatic int cnt_width(input int width);
        if (width > 1) begin
            return $clog2(width);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder built from two half-add stages.
module serial_fa_cell
    import serial_add_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;
    logic w_g;

    // First half-add stage: propagate and generate of the operand bits.
    assign w_p = a ^ b;
    assign w_g = a & b;

    // Second half-add stage: fold in the incoming carry.
    assign s    = w_p ^ cin;
    assign cout = w_g | (cin & w_p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: accepts one operand pair, adds it LSB first
// through a single full-adder cell over WIDTH cycles, then holds the result
// until the downstream handshake completes.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_last_bit;
    logic             w_cell_s;
    logic             w_cell_cout;
    logic [WIDTH-1:0] w_sum_shift;

    assign w_accept   = (r_state == IDLE) && i_valid;
    assign w_last_bit = (r_cnt == CNT_LAST);

    serial_fa_cell u_fa_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_cell_s),
        .cout (w_cell_cout)
    );

    // Sum register shifted right with the new cell sum entering at the MSB.
    always_comb begin
        w_sum_shift              = r_sum >> 1;
        w_sum_shift[WIDTH-1]     = w_cell_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: accept in IDLE, count WIDTH bits in RUN, wait for ready in DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (w_last_bit) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            DONE: begin
                if (i_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the state register only.
    always_comb begin
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
            end
            RUN: begin
                o_busy  = 1'b1;
            end
            DONE: begin
                o_valid = 1'b1;
                o_busy  = 1'b1;
            end
            default: begin
                o_ready = 1'b0;
            end
        endcase
    end

    // Datapath: capture operands on acceptance, then shift one bit per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sum   <= w_sum_shift;
            r_carry <= w_cell_cout;
            r_cnt   <= r_cnt + CNT_ONE;
        end
    end

    assign o_sum   = r_sum;
    assign o_carry = r_carry;

endmodule
